// File: rtl/lcg_pkg.sv
// lcg_pkg: constants and types shared by the 64-bit LCG generator and the
// receive-side stream checker.
//   LCG_MULTIPLIER / LCG_INCREMENT : recurrence x' = x*A + C (mod 2^64)
//   lcg_state_t                    : checker lock state
package lcg_pkg;

    localparam logic [63:0] LCG_MULTIPLIER = 64'h5851F42D4C957F2D;
    localparam logic [63:0] LCG_INCREMENT  = 64'h14057B7EF767814F;

    // Width of the consecutive-miss counter; holds LOSS_THRESH up to 15.
    localparam int RUN_W = 4;

    typedef enum logic [0:0] {
        ACQUIRE = 1'b0,
        LOCKED  = 1'b1
    } lcg_state_t;

endpackage : lcg_pkg

// File: rtl/lcg_step.sv
// lcg_step: purely combinational 64-bit LCG next-state function.
//   cur  : current 64-bit state
//   nxt  : low64(cur*MULTIPLIER) + INCREMENT
// Shared by the generator and the checker so both use identical arithmetic.
module lcg_step
    import lcg_pkg::*;
#(
    parameter logic [63:0] MULTIPLIER = LCG_MULTIPLIER,
    parameter logic [63:0] INCREMENT  = LCG_INCREMENT
) (
    input  logic [63:0] cur,
    output logic [63:0] nxt
);

    // 64-bit context: only the low half of the product is kept.
    assign nxt = (cur * MULTIPLIER) + INCREMENT;

endmodule : lcg_step

// File: rtl/lcg_stream_checker.sv
// lcg_stream_checker: locks onto an incoming LCG word stream and checks
// every following word against a free-running prediction.
//   clk, rst         : clock (rising edge), asynchronous active-high reset
//   clear            : synchronous return to ACQUIRE with counters zeroed
//   sample_valid/data: received word, one per cycle, no back-pressure
//   locked           : high while in LOCKED
//   match_pulse      : registered one-cycle pulse, word matched
//   mismatch_pulse   : registered one-cycle pulse, word mismatched
//   lost_pulse       : registered one-cycle pulse, lock dropped
//   match_count      : saturating count of matches
//   mismatch_count   : saturating count of mismatches
//   expected         : current prediction register
module lcg_stream_checker
    import lcg_pkg::*;
#(
    parameter logic [63:0] MULTIPLIER  = LCG_MULTIPLIER,
    parameter logic [63:0] INCREMENT   = LCG_INCREMENT,
    parameter int          LOSS_THRESH = 4,
    parameter int          CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             sample_valid,
    input  logic [63:0]      sample_data,
    output logic             locked,
    output logic             match_pulse,
    output logic             mismatch_pulse,
    output logic             lost_pulse,
    output logic [CNT_W-1:0] match_count,
    output logic [CNT_W-1:0] mismatch_count,
    output logic [63:0]      expected
);

    localparam logic [RUN_W-1:0] LOSS_LIMIT = RUN_W'(LOSS_THRESH);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    lcg_state_t       state_r;
    logic [RUN_W-1:0] miss_run_r;
    logic [RUN_W-1:0] miss_run_inc_s;
    logic [63:0]      step_in_s;
    logic [63:0]      step_out_s;

    // In ACQUIRE the prediction is seeded from the received word; once locked
    // it advances from the previous prediction regardless of match outcome.
    assign step_in_s      = (state_r == LOCKED) ? expected : sample_data;
    assign miss_run_inc_s = miss_run_r + RUN_W'(1);

    lcg_step #(
        .MULTIPLIER (MULTIPLIER),
        .INCREMENT  (INCREMENT)
    ) u_step (
        .cur (step_in_s),
        .nxt (step_out_s)
    );

    // Lock state machine, counters, prediction and registered pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= ACQUIRE;
            miss_run_r     <= '0;
            locked         <= 1'b0;
            match_pulse    <= 1'b0;
            mismatch_pulse <= 1'b0;
            lost_pulse     <= 1'b0;
            match_count    <= '0;
            mismatch_count <= '0;
            expected       <= 64'h0;
        end else if (clear) begin
            // Clear wins over a coincident sample; the sample is dropped and
            // no lost_pulse is raised.
            state_r        <= ACQUIRE;
            miss_run_r     <= '0;
            locked         <= 1'b0;
            match_pulse    <= 1'b0;
            mismatch_pulse <= 1'b0;
            lost_pulse     <= 1'b0;
            match_count    <= '0;
            mismatch_count <= '0;
            expected       <= 64'h0;
        end else begin
            match_pulse    <= 1'b0;
            mismatch_pulse <= 1'b0;
            lost_pulse     <= 1'b0;
            if (sample_valid) begin
                case (state_r)
                    ACQUIRE: begin
                        expected   <= step_out_s;
                        miss_run_r <= '0;
                        state_r    <= LOCKED;
                        locked     <= 1'b1;
                    end
                    LOCKED: begin
                        expected <= step_out_s;
                        if (sample_data == expected) begin
                            match_pulse <= 1'b1;
                            miss_run_r  <= '0;
                            if (match_count != CNT_MAX) begin
                                match_count <= match_count + CNT_W'(1);
                            end else begin
                                match_count <= match_count;
                            end
                        end else begin
                            mismatch_pulse <= 1'b1;
                            if (mismatch_count != CNT_MAX) begin
                                mismatch_count <= mismatch_count + CNT_W'(1);
                            end else begin
                                mismatch_count <= mismatch_count;
                            end
                            if (miss_run_inc_s == LOSS_LIMIT) begin
                                lost_pulse <= 1'b1;
                                miss_run_r <= '0;
                                state_r    <= ACQUIRE;
                                locked     <= 1'b0;
                            end else begin
                                miss_run_r <= miss_run_inc_s;
                            end
                        end
                    end
                    default: begin
                        state_r    <= ACQUIRE;
                        miss_run_r <= '0;
                        locked     <= 1'b0;
                    end
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end

endmodule : lcg_stream_checker

// File: tb/tb_lcg_stream_checker.sv
// Testbench for lcg_stream_checker: directed sequence with random data,
// checked against a behavioural stream model.
module tb_lcg_stream_checker;

    localparam logic [63:0] MUL = 64'h5851F42D4C957F2D;
    localparam logic [63:0] INC = 64'h14057B7EF767814F;
    localparam int          SAT16 = 65535;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        sample_valid = 1'b0;
    logic [63:0] sample_data = 64'h0;
    logic        locked, match_pulse, mismatch_pulse, lost_pulse;
    logic [15:0] match_count, mismatch_count;
    logic [63:0] expected;

    logic        s_clear = 1'b0;
    logic        s_valid = 1'b0;
    logic [63:0] s_data = 64'h0;
    logic        s_locked, s_mp, s_xp, s_lp;
    logic [3:0]  s_match_count, s_mismatch_count;
    logic [63:0] s_expected;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit          m_locked, m_mp, m_xp, m_lp, m_exp_known;
    logic [63:0] m_exp;
    int          m_match, m_mis, m_run;

    always #5 clk = ~clk;

    lcg_stream_checker dut (
        .clk(clk), .rst(rst), .clear(clear),
        .sample_valid(sample_valid), .sample_data(sample_data),
        .locked(locked), .match_pulse(match_pulse),
        .mismatch_pulse(mismatch_pulse), .lost_pulse(lost_pulse),
        .match_count(match_count), .mismatch_count(mismatch_count),
        .expected(expected)
    );

    lcg_stream_checker #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .clear(s_clear),
        .sample_valid(s_valid), .sample_data(s_data),
        .locked(s_locked), .match_pulse(s_mp),
        .mismatch_pulse(s_xp), .lost_pulse(s_lp),
        .match_count(s_match_count), .mismatch_count(s_mismatch_count),
        .expected(s_expected)
    );

    function automatic logic [63:0] f(input logic [63:0] x);
        logic [63:0] p;
        p = x * MUL;
        return p + INC;
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_locked = 0; m_mp = 0; m_xp = 0; m_lp = 0;
        m_exp = 64'h0; m_exp_known = 1; m_match = 0; m_mis = 0; m_run = 0;
    endtask

    task automatic model_update(input bit v, input logic [63:0] d, input bit c);
        m_mp = 0; m_xp = 0; m_lp = 0;
        if (c) begin
            m_locked = 0; m_match = 0; m_mis = 0; m_run = 0; m_exp_known = 0;
        end else if (v) begin
            if (!m_locked) begin
                m_exp = f(d); m_exp_known = 1; m_locked = 1; m_run = 0;
            end else if (d == m_exp) begin
                m_mp = 1; m_match++; m_run = 0; m_exp = f(m_exp);
            end else begin
                m_xp = 1; m_mis++; m_run++; m_exp = f(m_exp);
                if (m_run == 4) begin
                    m_lp = 1; m_locked = 0; m_run = 0;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".locked"}, 64'(locked), 64'(m_locked));
        chk({tag, ".match_pulse"}, 64'(match_pulse), 64'(m_mp));
        chk({tag, ".mismatch_pulse"}, 64'(mismatch_pulse), 64'(m_xp));
        chk({tag, ".lost_pulse"}, 64'(lost_pulse), 64'(m_lp));
        chk({tag, ".match_count"}, 64'(match_count), 64'(sat(m_match, SAT16)));
        chk({tag, ".mismatch_count"}, 64'(mismatch_count), 64'(sat(m_mis, SAT16)));
        if (m_exp_known) chk({tag, ".expected"}, expected, m_exp);
    endtask

    // One clock of stimulus on the main instance, then model update and checks.
    task automatic step(input string tag, input bit v, input logic [63:0] d, input bit c);
        sample_valid = v; sample_data = d; clear = c;
        @(posedge clk); #1;
        model_update(v, d, c);
        check_all(tag);
        sample_valid = 1'b0; clear = 1'b0;
    endtask

    initial begin
        logic [63:0] x;
        logic [63:0] w;

        // Reset state
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        chk("reset.sat_match_count", 64'(s_match_count), 64'h0);
        @(negedge clk) rst = 1'b0;
        step("idle", 0, 64'h0, 0);

        // Seed 1 acquisition
        step("seed1_acq", 1, 64'h1, 0);
        chk("seed1_pred", expected, 64'h6C576FAC43FD007C);
        step("seed1_match", 1, 64'h6C576FAC43FD007C, 0);
        chk("seed1_match_count", 64'(match_count), 64'h1);
        step("pulse_end", 0, 64'h0, 0);

        // clear with a valid sample while locked
        step("clear_locked", 1, {$urandom, $urandom}, 1);
        chk("clear.lost_pulse", 64'(lost_pulse), 64'h0);
        chk("clear.locked", 64'(locked), 64'h0);

        // Seed 0: 1000 correct words with random gaps
        x = 64'h0;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) step("gap", 0, {$urandom, $urandom}, 0);
            step("run1000", 1, x, 0);
            x = f(x);
        end
        chk("run1000.match_count", 64'(match_count), 64'd999);
        chk("run1000.mismatch_count", 64'(mismatch_count), 64'd0);
        chk("run1000.locked", 64'(locked), 64'd1);

        // Single corrupted word
        step("corr_clear", 0, 64'h0, 1);
        step("corr_acq", 1, 64'h0, 0);
        step("corr_bad", 1, 64'h14057B7EF767814F ^ 64'h1, 0);
        chk("corr.mismatch_pulse", 64'(mismatch_pulse), 64'h1);
        x = f(64'h14057B7EF767814F);
        for (int i = 0; i < 6; i++) begin
            step("corr_follow", 1, x, 0);
            x = f(x);
        end
        chk("corr.mismatch_count", 64'(mismatch_count), 64'd1);
        chk("corr.match_count", 64'(match_count), 64'd6);
        chk("corr.locked", 64'(locked), 64'd1);

        // Lock loss after 4 consecutive wrong words
        step("loss_clear", 0, 64'h0, 1);
        step("loss_acq", 1, {$urandom, $urandom}, 0);
        for (int i = 0; i < 4; i++) begin
            w = m_exp ^ {32'h0, ($urandom | 32'h1)};
            step("loss_bad", 1, w, 0);
        end
        chk("loss.lost_pulse", 64'(lost_pulse), 64'h1);
        chk("loss.mismatch_pulse", 64'(mismatch_pulse), 64'h1);
        chk("loss.locked", 64'(locked), 64'h0);
        chk("loss.mismatch_count", 64'(mismatch_count), 64'd4);
        step("reacq", 1, {$urandom, $urandom}, 0);
        chk("reacq.locked", 64'(locked), 64'h1);
        step("reacq_match", 1, m_exp, 0);

        // A miss run broken by a match does not drop lock
        for (int i = 0; i < 3; i++) step("run_bad", 1, ~m_exp, 0);
        step("run_good", 1, m_exp, 0);
        for (int i = 0; i < 3; i++) step("run_bad2", 1, ~m_exp, 0);
        chk("run_break.locked", 64'(locked), 64'h1);

        // Asynchronous reset mid-stream
        sample_valid = 1'b1; sample_data = m_exp;
        #2;
        rst = 1'b1;
        #1;
        sample_valid = 1'b0;
        chk("arst.locked", 64'(locked), 64'h0);
        chk("arst.match_pulse", 64'(match_pulse), 64'h0);
        chk("arst.match_count", 64'(match_count), 64'h0);
        chk("arst.mismatch_count", 64'(mismatch_count), 64'h0);
        chk("arst.expected", expected, 64'h0);
        model_reset();
        @(negedge clk) rst = 1'b0;
        step("post_rst_acq", 1, 64'h1, 0);
        chk("post_rst.expected", expected, 64'h6C576FAC43FD007C);
        step("post_rst_match", 1, 64'h6C576FAC43FD007C, 0);

        // Saturation on the 4-bit-counter instance
        x = {$urandom, $urandom};
        for (int i = 0; i < 21; i++) begin
            s_valid = 1'b1; s_data = x;
            @(posedge clk); #1;
            x = f(x);
        end
        s_valid = 1'b0;
        chk("sat.match_count", 64'(s_match_count), 64'hF);
        chk("sat.mismatch_count", 64'(s_mismatch_count), 64'h0);
        chk("sat.locked", 64'(s_locked), 64'h1);
        chk("sat.expected", s_expected, x);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_lcg_stream_checker

// File: doc/lcg_stream_checker.md
# lcg_stream_checker

Receive-side companion to the 64-bit LCG generator. It consumes the generator's output word stream, locks onto the sequence from the first accepted word and predicts each following word with the same recurrence. It flags and counts mismatches, and drops lock after a run of consecutive misses. It sits downstream of the PRNG core, or at the far end of a link carrying PRNG words, as a built-in integrity and self-test monitor.

## Interface
- MULTIPLIER, 64'h5851F42D4C957F2D, LCG multiplier (must equal generator's)
- INCREMENT, 64'h14057B7EF767814F, LCG increment
- LOSS_THRESH, 4, consecutive mismatches that drop lock (legal 1..15)
- CNT_W, 16, width of the match and mismatch counters
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- clear  in  1  synchronous clear: back to ACQUIRE, counters zeroed
- sample_valid  in  1  sample_data is valid this cycle
- sample_data  in  64  received PRNG word
- locked  out  1  high while in LOCKED
- match_pulse  out  1  one-cycle pulse: checked word matched
- mismatch_pulse  out  1  one-cycle pulse: checked word mismatched
- lost_pulse  out  1  one-cycle pulse: lock dropped
- match_count  out  CNT_W  saturating count of matches
- mismatch_count  out  CNT_W  saturating count of mismatches
- expected  out  64  current prediction register

## Operation
- Reset: state=ACQUIRE. All outputs 0, expected=0, miss run counter=0.
- Next-state function: f(x) = low64(x*MULTIPLIER) + INCREMENT mod 2^64. Only the low 64 bits of the product are used.
- ACQUIRE, sample_valid: expected<=f(sample_data), go to LOCKED. No match or mismatch pulse, counters unchanged.
- LOCKED, sample_valid, sample_data==expected:
  - match_pulse
  - match_count+1, saturating at all-ones
  - miss run counter cleared
  - expected<=f(expected)
- LOCKED, sample_valid, sample_data!=expected:
  - mismatch_pulse
  - mismatch_count+1, saturating
  - miss run counter+1
  - expected<=f(expected): the predictor free-runs, so one corrupted word costs exactly one mismatch.
- Lock loss: when the miss run counter reaches LOSS_THRESH on a mismatch, go to ACQUIRE and pulse lost_pulse. That mismatch_pulse, lost_pulse and locked deassertion happen on the same edge. Miss run counter resets to 0.
- sample_valid low: no state change. Idle gaps of any length are allowed and do not advance the predictor.
- Priority: clear overrides sample_valid. A sample presented with clear is dropped. clear does not pulse lost_pulse.
- Counters are never cleared by lock loss, only by clear or rst.

## Timing
- Accepts one sample per cycle, no back-pressure.
- Sample accepted at edge N. match_pulse, mismatch_pulse, lost_pulse, locked, counters and expected all update at edge N, visible in cycle N+1.
- Pulses are registered and last exactly one cycle unless the next sample retriggers them.
- Back-to-back samples: a prediction for every cycle is required, so f(expected) is a single-cycle combinational path. No multiplier pipelining.
- rst asserted mid-stream: immediate return to reset values. The first valid sample after release is treated as an acquisition word.

## Structure
- Shared package lcg_pkg holds:
  - LCG_MULTIPLIER and LCG_INCREMENT constants, shared with the generator
  - state enum {ACQUIRE, LOCKED}
- Sub-module lcg_step: purely combinational 64-bit next-state function with parameters MULTIPLIER and INCREMENT. The checker instantiates it once. The generator reuses it.

## Test plan
- Seed 1 acquisition: send 1, then 0x6C576FAC43FD007C.
  - Edge after the first word: locked=1, no pulses.
  - After the second word: match_pulse=1, match_count=1.
- Seed 0, 1000 consecutive correct words from a reference model, gaps inserted randomly: match_count=999, mismatch_count=0, locked stays 1.
- Single corruption: lock on seed 0, then send 0x14057B7EF767814F with bit 0 flipped, then correct words. Exactly one mismatch_pulse, mismatch_count=1, locked stays 1, the following words match.
- Lock loss with LOSS_THRESH=4: after lock, send 4 wrong words. lost_pulse fires on the 4th with mismatch_pulse, locked=0, mismatch_count=4. The next word re-acquires.
- Saturation with CNT_W=4: 20 matching words leave match_count=15.
- clear and rst:
  - clear together with sample_valid in LOCKED: sample dropped, counters=0, state ACQUIRE, no lost_pulse.
  - rst pulsed mid-stream: all outputs return to 0 asynchronously.
